// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: load-use bubbles, data-memory wait freezes, branch flushes, timeout lock.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_unit #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       RA_ID,
  input  logic [4:0]       RB_ID,
  input  logic [4:0]       RD_EX,
  input  logic             RF_LE_EX,
  input  logic             MEM_RE_EX,
  input  logic             MEM_ACC_MEM,
  input  logic             MEM_READY,
  input  logic             BR_TAKEN_EX,
  output logic             PC_LE,
  output logic             IF_ID_LE,
  output logic             ID_EX_LE,
  output logic             EX_MEM_LE,
  output logic             MEM_WB_LE,
  output logic             NOP_EX,
  output logic             FLUSH_IF_ID,
  output logic             MEM_ERR,
  output logic [1:0]       STATE
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] CNT_BUBBLE,
  output logic [CNT_W-1:0] CNT_WAIT,
  output logic [CNT_W-1:0] CNT_FLUSH
`endif
);

  localparam int unsigned TO_W = 16;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'b00,
    S_MEM_WAIT = 2'b01,
    S_ERR      = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            live_q;
  logic            lu, mw;
  logic            pri_wait, pri_flush, pri_bubble;

  assign lu = MEM_RE_EX & RF_LE_EX & (RD_EX != 5'd0) &
              ((RD_EX == RA_ID) | (RD_EX == RB_ID));
  assign mw = MEM_ACC_MEM & ~MEM_READY;

  assign STATE = state_q;

  // live_q holds outputs at their reset values until the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      to_cnt_q <= '0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      live_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    PC_LE       = 1'b0;
    IF_ID_LE    = 1'b0;
    ID_EX_LE    = 1'b0;
    EX_MEM_LE   = 1'b0;
    MEM_WB_LE   = 1'b0;
    NOP_EX      = 1'b1;
    FLUSH_IF_ID = 1'b1;
    MEM_ERR     = 1'b0;
    pri_wait    = 1'b0;
    pri_flush   = 1'b0;
    pri_bubble  = 1'b0;

    if (live_q) begin
      if (state_q == S_ERR) begin
        MEM_ERR     = 1'b1;
        NOP_EX      = 1'b1;
        FLUSH_IF_ID = 1'b0;
      end else begin
        if (mw) begin
          pri_wait    = 1'b1;
          NOP_EX      = 1'b0;
          FLUSH_IF_ID = 1'b0;
        end else if (BR_TAKEN_EX) begin
          pri_flush   = 1'b1;
          PC_LE       = 1'b1;
          IF_ID_LE    = 1'b1;
          ID_EX_LE    = 1'b1;
          EX_MEM_LE   = 1'b1;
          MEM_WB_LE   = 1'b1;
        end else if (lu) begin
          pri_bubble  = 1'b1;
          ID_EX_LE    = 1'b1;
          EX_MEM_LE   = 1'b1;
          MEM_WB_LE   = 1'b1;
          FLUSH_IF_ID = 1'b0;
        end else begin
          PC_LE       = 1'b1;
          IF_ID_LE    = 1'b1;
          ID_EX_LE    = 1'b1;
          EX_MEM_LE   = 1'b1;
          MEM_WB_LE   = 1'b1;
          NOP_EX      = 1'b0;
          FLUSH_IF_ID = 1'b0;
        end

        if (state_q == S_RUN) begin
          to_cnt_d = '0;
          if (mw) state_d = S_MEM_WAIT;
        end else if (!mw) begin
          state_d  = S_RUN;
          to_cnt_d = '0;
        end else if (to_cnt_q >= TO_LAST) begin
          state_d = S_ERR;
        end else if (to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating event counters; the priority flags are already zero in ERR and before go-live
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      CNT_BUBBLE <= '0;
      CNT_WAIT   <= '0;
      CNT_FLUSH  <= '0;
    end else begin
      if (pri_bubble && (CNT_BUBBLE != '1)) CNT_BUBBLE <= CNT_BUBBLE + CNT_W'(1);
      if (pri_wait   && (CNT_WAIT   != '1)) CNT_WAIT   <= CNT_WAIT   + CNT_W'(1);
      if (pri_flush  && (CNT_FLUSH  != '1)) CNT_FLUSH  <= CNT_FLUSH  + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: combinational priority table plus freeze, timeout and reset sequences.
module tb_hazard_stall_unit;

  localparam int unsigned TO    = 4;
  localparam int unsigned CW    = 8;

  localparam logic [6:0] NORM = 7'b1111100;
  localparam logic [6:0] BUB  = 7'b0011110;
  localparam logic [6:0] FLU  = 7'b1111111;
  localparam logic [6:0] FRZ  = 7'b0000000;
  localparam logic [6:0] RSTV = 7'b0000011;
  localparam logic [6:0] ERRV = 7'b0000010;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] ra, rb, rd;
  logic       rf_le, mem_re, acc, rdy, br;
  logic       pc_le, ifid_le, idex_le, exmem_le, memwb_le, nop_ex, flush, mem_err;
  logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] cnt_bubble, cnt_wait, cnt_flush;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .RA_ID(ra), .RB_ID(rb), .RD_EX(rd), .RF_LE_EX(rf_le), .MEM_RE_EX(mem_re),
    .MEM_ACC_MEM(acc), .MEM_READY(rdy), .BR_TAKEN_EX(br),
    .PC_LE(pc_le), .IF_ID_LE(ifid_le), .ID_EX_LE(idex_le), .EX_MEM_LE(exmem_le),
    .MEM_WB_LE(memwb_le), .NOP_EX(nop_ex), .FLUSH_IF_ID(flush),
    .MEM_ERR(mem_err), .STATE(state)
`ifdef HAZARD_PERF_CNT_EN
    , .CNT_BUBBLE(cnt_bubble), .CNT_WAIT(cnt_wait), .CNT_FLUSH(cnt_flush)
`endif
  );

  typedef struct {
    logic [4:0] ra, rb, rd;
    logic       rf_le, mem_re, acc, rdy, br;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic set_in(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                        input logic f, input logic m, input logic c, input logic r, input logic t);
    ra = a; rb = b; rd = d; rf_le = f; mem_re = m; acc = c; rdy = r; br = t;
  endtask

  task automatic chk(input string name, input logic [6:0] exp_o, input logic [1:0] exp_st,
                     input logic exp_err);
    logic [9:0] act, exp;
    act = {pc_le, ifid_le, idex_le, exmem_le, memwb_le, nop_ex, flush, state, mem_err};
    exp = {exp_o, exp_st, exp_err};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b (le5,nop,flush,state,err)", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    vecs[0] = '{5'd1,  5'd5,  5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, BUB};
    vecs[1] = '{5'd0,  5'd3,  5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, NORM};
    vecs[2] = '{5'd7,  5'd3,  5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, BUB};
    vecs[3] = '{5'd9,  5'd9,  5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, BUB};
    vecs[4] = '{5'd5,  5'd2,  5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, NORM};
    vecs[5] = '{5'd5,  5'd2,  5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NORM};
    vecs[6] = '{5'd1,  5'd5,  5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, FLU};
    vecs[7] = '{5'd1,  5'd2,  5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FLU};
    vecs[8] = '{5'd6,  5'd1,  5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, BUB};
    vecs[9] = '{5'd1,  5'd2,  5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, NORM};

    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #12;
    chk("reset_hold", RSTV, 2'b00, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("released_before_edge", RSTV, 2'b00, 1'b0);
    tick();
    chk("first_live_cycle", NORM, 2'b00, 1'b0);

    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].ra, vecs[i].rb, vecs[i].rd, vecs[i].rf_le, vecs[i].mem_re,
             vecs[i].acc, vecs[i].rdy, vecs[i].br);
      #3;
      chk($sformatf("table_%0d", i), vecs[i].exp, 2'b00, 1'b0);
      tick();
    end

    // single bubble, then EX holds the NOP
    set_in(5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #3; chk("lu_bubble", BUB, 2'b00, 1'b0);
    tick();
    set_in(5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3; chk("lu_after_bubble", NORM, 2'b00, 1'b0);
    tick();

    // branch with lu: flush, no bubble afterwards
    set_in(5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    #3; chk("br_over_lu", FLU, 2'b00, 1'b0);
    tick();
    set_in(5'd2, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3; chk("br_next_cycle", NORM, 2'b00, 1'b0);
    tick();

    // three-cycle memory wait with a branch arriving mid-freeze
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #3; chk("wait_c1", FRZ, 2'b00, 1'b0);
    tick();
    br = 1'b1;
    #3; chk("wait_c2_br_ignored", FRZ, 2'b01, 1'b0);
    tick();
    br = 1'b0;
    #3; chk("wait_c3", FRZ, 2'b01, 1'b0);
    tick();
    rdy = 1'b1;
    #3; chk("wait_release", NORM, 2'b01, 1'b0);
    tick();
    acc = 1'b0;
    #3; chk("wait_back_run", NORM, 2'b00, 1'b0);
    tick();

    // MEM_ACC_MEM dropping also releases
    acc = 1'b1; rdy = 1'b0;
    tick();
    acc = 1'b0;
    #3; chk("acc_drop_release", NORM, 2'b01, 1'b0);
    tick();
    #3; chk("acc_drop_run", NORM, 2'b00, 1'b0);

    // timeout into ERR on the 5th edge
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1; chk("to_start", FRZ, 2'b00, 1'b0);
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk($sformatf("to_edge_%0d", e), FRZ, 2'b01, 1'b0);
    end
    tick();
    chk("to_err_entered", ERRV, 2'b10, 1'b1);
    set_in(5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    #3; chk("err_ignores_inputs", ERRV, 2'b10, 1'b1);
    tick();
    chk("err_sticky", ERRV, 2'b10, 1'b1);
    #2; rst_n = 1'b0;
    #1; chk("err_async_reset", RSTV, 2'b00, 1'b0);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2; rst_n = 1'b1;
    tick();
    chk("post_err_run", NORM, 2'b00, 1'b0);

    // reset mid-freeze forgets the pending wait
    acc = 1'b1; rdy = 1'b0;
    tick();
    #1; rst_n = 1'b0;
    #1; chk("freeze_async_reset", RSTV, 2'b00, 1'b0);
    acc = 1'b0;
    #1; rst_n = 1'b1;
    tick();
    chk("post_freeze_run", NORM, 2'b00, 1'b0);

`ifdef HAZARD_PERF_CNT_EN
    do_reset();
    chk_cnt("cnt_bubble_clr", cnt_bubble, CW'(0));
    set_in(5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    rdy = 1'b1;
    tick();
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    br = 1'b0;
    tick();
    chk_cnt("cnt_bubble", cnt_bubble, CW'(2));
    chk_cnt("cnt_wait",   cnt_wait,   CW'(3));
    chk_cnt("cnt_flush",  cnt_flush,  CW'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline hazard controller that works alongside the forwarding mux selectors.
- Forwarding handles hazards that can be satisfied by passing results to consumers. This block handles the hazards forwarding cannot resolve:
  - load-use bubbles;
  - data-memory wait freezes;
  - taken-branch flushes;
  - a memory-timeout error lock.
- Drives the load enables of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, plus the bubble and flush controls.

Parameters:
- MEM_TIMEOUT, 64: maximum consecutive MEM_WAIT cycles before error; legal range 2..65535.
- CNT_W, 32: width of the optional performance counters.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- RA_ID  in  5  rs1 of the instruction in ID.
- RB_ID  in  5  rs2 of the instruction in ID.
- RD_EX  in  5  destination register in EX.
- RF_LE_EX  in  1  register-file write enable of the EX instruction.
- MEM_RE_EX  in  1  EX instruction is a load.
- MEM_ACC_MEM  in  1  MEM-stage instruction accesses data memory.
- MEM_READY  in  1  data memory completes the access this cycle.
- BR_TAKEN_EX  in  1  branch/jump resolved taken in EX.
- PC_LE  out  1  PC load enable.
- IF_ID_LE  out  1  IF/ID load enable.
- ID_EX_LE  out  1  ID/EX load enable.
- EX_MEM_LE  out  1  EX/MEM load enable.
- MEM_WB_LE  out  1  MEM/WB load enable.
- NOP_EX  out  1  zero the control bits loaded into ID/EX (bubble).
- FLUSH_IF_ID  out  1  replace the IF/ID contents with NOP.
- MEM_ERR  out  1  sticky memory-timeout flag.
- STATE  out  2  current FSM state, for debug.

Behaviour:
- FSM states:
  - RUN = 2'b00;
  - MEM_WAIT = 2'b01;
  - ERR = 2'b10.
- The state register and the timeout counter reset asynchronously on rst_n=0.
- Values while rst_n=0:
  - STATE = RUN;
  - MEM_ERR = 0;
  - all LE outputs = 0;
  - NOP_EX = 1;
  - FLUSH_IF_ID = 1.
- From the first clk edge after reset release, outputs follow the rules below. They are combinational from state plus inputs, with zero latency.
- Definitions:
  - lu = MEM_RE_EX & RF_LE_EX & (RD_EX!=0) & ((RD_EX==RA_ID) | (RD_EX==RB_ID));
  - mw = MEM_ACC_MEM & ~MEM_READY.
- Priority in RUN/MEM_WAIT, highest first:
  1. mw: freeze. All five LE = 0, NOP_EX = 0, FLUSH_IF_ID = 0. BR_TAKEN_EX and lu are ignored; they are re-evaluated after release because the EX instruction is held.
  2. BR_TAKEN_EX: all LE = 1, FLUSH_IF_ID = 1, NOP_EX = 1. Any lu is discarded because the ID instruction is wrong-path.
  3. lu: PC_LE = 0, IF_ID_LE = 0, ID_EX_LE = 1, EX_MEM_LE = 1, MEM_WB_LE = 1, NOP_EX = 1. This is exactly one bubble; the next cycle EX holds a NOP, so lu deasserts and forwarding from MEM supplies the data.
  4. Otherwise: all LE = 1, NOP_EX = 0, FLUSH_IF_ID = 0.
- Transitions and timeout counter:
  - RUN -> MEM_WAIT when mw.
  - MEM_WAIT -> RUN when MEM_READY=1, or when MEM_ACC_MEM drops. On that cycle the pipeline advances normally and priorities 2–4 apply.
  - Timeout counter: cleared in RUN, incremented each MEM_WAIT cycle with mw.
  - MEM_WAIT -> ERR when the counter reaches MEM_TIMEOUT-1 and mw is still 1.
  - With MEM_READY held low from the first mw cycle, ERR is entered on the (MEM_TIMEOUT+1)th clk edge.
  - The counter saturates and never wraps.
- ERR state:
  - MEM_ERR = 1;
  - all LE = 0, NOP_EX = 1, FLUSH_IF_ID = 0;
  - the state is left only by rst_n.
- Reset asserted mid-freeze or in ERR returns immediately to the reset values. No pending hazard is remembered.
- Register x0 never causes lu. RA_ID == RB_ID == RD_EX produces a single bubble, not two.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, three CNT_W-bit counters are added, with outputs:
  - CNT_BUBBLE: cycles where priority 3 is active;
  - CNT_WAIT: cycles where priority 1 is active;
  - CNT_FLUSH: cycles where priority 2 is active.
- Counter behaviour:
  - asynchronous clear on rst_n;
  - saturate at all-ones;
  - do not count in ERR.
- When undefined, the ports and logic are absent and the FSM behaviour is identical.

Test Plan:
- Load x5 in EX (MEM_RE_EX=1, RF_LE_EX=1, RD_EX=5) with RB_ID=5 -> exactly 1 cycle of PC_LE=0, IF_ID_LE=0, NOP_EX=1; next cycle all LE=1, NOP_EX=0.
- Same load with RD_EX=0, RA_ID=0 -> no bubble; all LE=1.
- MEM_ACC_MEM=1, MEM_READY=0 for 3 cycles, then 1 -> STATE=01 for 3 cycles with all LE=0; the release cycle has all LE=1 and STATE=00 afterwards.
- BR_TAKEN_EX=1 together with lu true -> FLUSH_IF_ID=1, NOP_EX=1, PC_LE=1; no bubble cycle follows.
- MEM_TIMEOUT=4, MEM_READY stuck at 0 -> MEM_ERR=1 and STATE=10 after the 5th edge; stays set until rst_n pulses low, then clears asynchronously.
- With HAZARD_PERF_CNT_EN: 2 bubbles, 3 wait cycles, 1 flush -> CNT_BUBBLE=2, CNT_WAIT=3, CNT_FLUSH=1.
